pipeline_stage_ctrl: RTL and testbench
======================================

Name: pipeline_stage_ctrl

Overview:
- Parametrised hazard/stall/flush controller for an N-stage in-order integer pipeline.
- Generates per-register enable and synchronous clear, plus the PC enable.
- Unlike a global freeze, a stall in stage j holds only stage j and upstream; bubbles drain downstream.
- Adds a fence/drain FSM, internal valid tracking, redirect back-pressure and saturating stall/flush counters.

Parameters:
- NUM_STAGES, 5, pipeline stages (0=IF .. N-1=WB); pipeline registers R[0..N-2], R[k] sits between stage k and stage k+1.
- FLUSH_DEPTH, 3, redirect clears R[0..FLUSH_DEPTH-1]; legal range 1..N-1.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- stall_req  in  NUM_STAGES  stage j cannot complete this cycle (bit 0 = fetch miss)
- load_hazard  in  1  load-use hazard; treated as stall_req[1]
- redirect  in  1  branch/exception redirect, level; source holds it until redirect_ready
- fence_req  in  1  single-cycle pulse: drain pipeline
- redirect_ready  out  1  redirect accepted this cycle
- fence_ack  out  1  one-cycle pulse: pipeline empty after fence
- stage_en  out  NUM_STAGES-1  enable for R[k]
- stage_clr  out  NUM_STAGES-1  sync clear for R[k]; clear beats enable
- pc_en  out  1  PC register enable
- pipe_empty  out  1  no valid instruction in R[0..N-2]
- ctrl_state  out  2  00 RUN, 01 DRAIN, 10 ACK
- stall_cycles  out  CNT_W  cycles in RUN with pc_en=0
- flush_count  out  CNT_W  accepted redirects

Behaviour:
Combinational terms:
- s = stall_req | (load_hazard << 1).
- hold[k] = OR of s[j] for j > k.
- bubble[k] = s[k] & ~hold[k].
- blk = OR of s[j] for j >= FLUSH_DEPTH.
- redirect_ready = redirect & ~blk.

Outputs:
- stage_en[k] = ~hold[k].
- stage_clr[k] = bubble[k] | (redirect_ready & k < FLUSH_DEPTH) | (state != RUN & k == 0 & ~hold[0]).
- pc_en:
  - 1 if redirect_ready (any state);
  - else 0 if state != RUN;
  - else ~|s.

Valid tracking:
- vld[k] <= 0 if stage_clr[k].
- Else vld[k] <= (k == 0 ? 1 : vld[k-1]) if stage_en[k].
- Else vld[k] holds.
- pipe_empty = ~|vld.

FSM (registered):
- RUN -> DRAIN when fence_req & ~redirect. A fence_req coincident with redirect is dropped; the source re-issues it.
- DRAIN -> ACK when pipe_empty & ~|s. Redirects are still accepted in DRAIN; the state is unchanged.
- ACK -> RUN unconditionally. fence_ack = (state == ACK).
- fence_req outside RUN is ignored.

Counters:
- stall_cycles += 1 when state == RUN & pc_en == 0.
- flush_count += 1 when redirect_ready.
- Both saturate at all-ones; no wrap.

Reset:
- Sync, rst_n == 0 at the clock edge, including mid-drain.
- state = RUN, vld = 0, both counters = 0; therefore pipe_empty = 1 and fence_ack = 0.
- Combinational outputs follow from inputs and this reset state.

Simultaneous events:
- Redirect plus a stall at a stage < FLUSH_DEPTH: the flush wins and the stalled instruction is squashed.
- Redirect plus a stall at a stage >= FLUSH_DEPTH: redirect_ready = 0, no clear, retry next cycle.
- Latency: enables and clears are zero-cycle combinational. FSM transitions and counters take effect one cycle later.

Test Plan (NUM_STAGES=5, FLUSH_DEPTH=3):
- No hazards, fence_req low -> stage_en = 4'b1111, stage_clr = 0, pc_en = 1; after 4 cycles pipe_empty = 0; stall_cycles stays 0.
- stall_req = 5'b01000 (MEM) for 3 cycles -> stage_en = 4'b1000, stage_clr = 4'b1000, pc_en = 0; stall_cycles = 3; vld[3] = 0 afterwards.
- load_hazard pulse 1 cycle -> stage_en = 4'b1110, stage_clr = 4'b0010, pc_en = 0 for exactly that cycle.
- Redirect, no stall -> redirect_ready = 1, stage_clr = 4'b0111, pc_en = 1, flush_count +1. Redirect with stall_req[3] = 1 for 2 cycles -> redirect_ready = 0 both cycles, then accepted in cycle 3.
- fence_req from a full pipe -> ctrl_state = DRAIN, pc_en = 0, stage_clr[0] = 1; after 4 cycles pipe_empty = 1, then ACK with fence_ack = 1 for one cycle, then RUN.
- rst_n low for 1 cycle while in DRAIN -> ctrl_state = RUN, counters = 0, pipe_empty = 1, fence_ack = 0. Also: force stall_cycles to all-ones plus a stall -> value holds at all-ones.

Source files
------------

// File: rtl/pipeline_stage_ctrl_if.sv
// Handshake bundle between the pipeline datapath (master) and the stage controller (slave).
// The master raises stall/hazard/redirect/fence requests; the slave returns enables and status.
interface pipeline_stage_ctrl_if #(
  parameter int NUM_STAGES = 5,
  parameter int CNT_W      = 32
);
  logic [NUM_STAGES-1:0] stall_req;
  logic                  load_hazard;
  logic                  redirect;
  logic                  fence_req;
  logic                  redirect_ready;
  logic                  fence_ack;
  logic [NUM_STAGES-2:0] stage_en;
  logic [NUM_STAGES-2:0] stage_clr;
  logic                  pc_en;
  logic                  pipe_empty;
  logic [1:0]            ctrl_state;
  logic [CNT_W-1:0]      stall_cycles;
  logic [CNT_W-1:0]      flush_count;

  modport master (
    output stall_req, load_hazard, redirect, fence_req,
    input  redirect_ready, fence_ack, stage_en, stage_clr, pc_en,
           pipe_empty, ctrl_state, stall_cycles, flush_count
  );

  modport slave (
    input  stall_req, load_hazard, redirect, fence_req,
    output redirect_ready, fence_ack, stage_en, stage_clr, pc_en,
           pipe_empty, ctrl_state, stall_cycles, flush_count
  );
endinterface

// File: rtl/pipeline_stage_ctrl.sv
// Stall/flush/fence controller for an in-order pipeline: per-register enable and clear,
// PC enable, valid tracking, drain FSM and saturating stall/flush counters.
module pipeline_stage_ctrl #(
  parameter int NUM_STAGES  = 5,
  parameter int FLUSH_DEPTH = 3,
  parameter int CNT_W       = 32
) (
  input logic                 clk,
  input logic                 rst_n,
  pipeline_stage_ctrl_if.slave bus
);
  localparam int NR = NUM_STAGES - 1;

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_DRAIN = 2'b01,
    ST_ACK   = 2'b10
  } state_t;

  state_t           r_state;
  logic             r_fence_ack;
  logic [NR-1:0]    r_vld;
  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] r_flush_count;

  logic [NUM_STAGES-1:0] w_s;
  logic [NR-1:0]         w_hold;
  logic [NR-1:0]         w_bubble;
  logic [NR-1:0]         w_en;
  logic [NR-1:0]         w_clr;
  logic [NR-1:0]         w_vld_in;
  logic [NR-1:0]         w_vld_next;
  logic                  w_blk;
  logic                  w_redirect_ready;
  logic                  w_run;
  logic                  w_pc_en;
  logic                  w_pipe_empty;
  logic                  w_any_stall;

  // A load-use hazard behaves exactly like a decode-stage stall.
  assign w_s              = bus.stall_req | (NUM_STAGES'(bus.load_hazard) << 1);
  assign w_any_stall      = |w_s;
  assign w_blk            = |(w_s >> FLUSH_DEPTH);
  assign w_redirect_ready = bus.redirect & ~w_blk;
  assign w_run            = (r_state == ST_RUN);
  assign w_pc_en          = w_redirect_ready | (w_run & ~w_any_stall);
  assign w_pipe_empty     = ~|r_vld;

  genvar gi;
  generate
    for (gi = 0; gi < NR; gi++) begin : g_reg
      // R[k] must hold whenever any stage downstream of it is stuck.
      assign w_hold[gi]   = |(w_s >> (gi + 1));
      assign w_bubble[gi] = w_s[gi] & ~w_hold[gi];
      assign w_en[gi]     = ~w_hold[gi];
      if (gi == 0) begin : g_first
        // Outside RUN no new instruction is fetched, so R[0] is fed a bubble.
        assign w_clr[gi]    = w_bubble[gi] | (w_redirect_ready & (gi < FLUSH_DEPTH)) |
                              (~w_run & ~w_hold[gi]);
        assign w_vld_in[gi] = 1'b1;
      end else begin : g_rest
        assign w_clr[gi]    = w_bubble[gi] | (w_redirect_ready & (gi < FLUSH_DEPTH));
        assign w_vld_in[gi] = r_vld[gi-1];
      end
      assign w_vld_next[gi] = ~w_clr[gi] & (w_en[gi] ? w_vld_in[gi] : r_vld[gi]);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= ST_RUN;
      r_fence_ack    <= 1'b0;
      r_vld          <= '0;
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      r_vld       <= w_vld_next;
      r_fence_ack <= 1'b0;
      case (r_state)
        // A fence colliding with a redirect is dropped; the source re-issues it.
        ST_RUN: if (bus.fence_req && !bus.redirect) r_state <= ST_DRAIN;
        ST_DRAIN: begin
          if (w_pipe_empty && !w_any_stall) begin
            r_state     <= ST_ACK;
            r_fence_ack <= 1'b1;
          end
        end
        ST_ACK:  r_state <= ST_RUN;
        default: r_state <= ST_RUN;
      endcase
      if (w_run && !w_pc_en && (r_stall_cycles != '1))
        r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      if (w_redirect_ready && (r_flush_count != '1))
        r_flush_count <= r_flush_count + CNT_W'(1);
    end
  end

  assign bus.redirect_ready = w_redirect_ready;
  assign bus.fence_ack      = r_fence_ack;
  assign bus.stage_en       = w_en;
  assign bus.stage_clr      = w_clr;
  assign bus.pc_en          = w_pc_en;
  assign bus.pipe_empty     = w_pipe_empty;
  assign bus.ctrl_state     = r_state;
  assign bus.stall_cycles   = r_stall_cycles;
  assign bus.flush_count    = r_flush_count;
endmodule

// File: tb/tb_pipeline_stage_ctrl.sv
// Scenario tests from the test plan plus a randomized run against a behavioural model
// of the stall/flush/fence rules.
module tb_pipeline_stage_ctrl;
  localparam int NS   = 5;
  localparam int NR   = NS - 1;
  localparam int FD   = 3;
  localparam int CW   = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  pipeline_stage_ctrl_if #(.NUM_STAGES(NS), .CNT_W(CW)) bus ();

  pipeline_stage_ctrl #(.NUM_STAGES(NS), .FLUSH_DEPTH(FD), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: which pipeline registers hold a live instruction, FSM phase, counters.
  bit      m_vld[NR];
  int      m_state;
  int      m_stall;
  int      m_flush;
  logic [NR-1:0] e_en;
  logic [NR-1:0] e_clr;
  logic    e_pc;
  logic    e_rr;
  bit      e_any;

  task automatic model_eval();
    bit s[NS];
    bit stuck_below;
    bit blocked;
    e_any   = 0;
    blocked = 0;
    for (int j = 0; j < NS; j++) begin
      s[j] = bus.stall_req[j] || (j == 1 && bus.load_hazard);
      if (s[j]) e_any = 1;
      if (s[j] && j >= FD) blocked = 1;
    end
    e_rr = bus.redirect && !blocked;
    for (int k = 0; k < NR; k++) begin
      stuck_below = 0;
      for (int j = k + 1; j < NS; j++) if (s[j]) stuck_below = 1;
      e_en[k]  = !stuck_below;
      e_clr[k] = (s[k] && !stuck_below) || (e_rr && k < FD) ||
                 (m_state != 0 && k == 0 && !stuck_below);
    end
    if (e_rr) e_pc = 1;
    else if (m_state != 0) e_pc = 0;
    else e_pc = !e_any;
  endtask

  function automatic bit model_empty();
    for (int k = 0; k < NR; k++) if (m_vld[k]) return 0;
    return 1;
  endfunction

  always @(posedge clk) begin
    bit nv[NR];
    bit was_empty;
    model_eval();
    if (!rst_n) begin
      for (int k = 0; k < NR; k++) m_vld[k] = 0;
      m_state = 0;
      m_stall = 0;
      m_flush = 0;
    end else begin
      was_empty = model_empty();
      for (int k = 0; k < NR; k++) begin
        if (e_clr[k]) nv[k] = 0;
        else if (e_en[k]) nv[k] = (k == 0) ? 1'b1 : m_vld[k-1];
        else nv[k] = m_vld[k];
      end
      if (m_state == 0 && !e_pc && m_stall < CMAX) m_stall++;
      if (e_rr && m_flush < CMAX) m_flush++;
      case (m_state)
        0: if (bus.fence_req && !bus.redirect) m_state = 1;
        1: if (was_empty && !e_any) m_state = 2;
        default: m_state = 0;
      endcase
      for (int k = 0; k < NR; k++) m_vld[k] = nv[k];
    end
  end

  task automatic drive(input logic [NS-1:0] st, input logic lh, input logic rd,
                       input logic fr, input logic rn);
    @(negedge clk);
    bus.stall_req   = st;
    bus.load_hazard = lh;
    bus.redirect    = rd;
    bus.fence_req   = fr;
    rst_n           = rn;
    #1;
    model_eval();
  endtask

  task automatic do_reset();
    drive('0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    do_reset();
    drive('0, 0, 0, 0, 1);
    checks += 6;
    if (bus.ctrl_state !== 2'b00) begin failures++; $display("FAIL reset_state got=%b exp=00", bus.ctrl_state); end
    if (bus.stall_cycles !== '0) begin failures++; $display("FAIL reset_stall got=%0d exp=0", bus.stall_cycles); end
    if (bus.flush_count !== '0) begin failures++; $display("FAIL reset_flush got=%0d exp=0", bus.flush_count); end
    if (bus.pipe_empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", bus.pipe_empty); end
    if (bus.fence_ack !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b exp=0", bus.fence_ack); end
    if (bus.stage_en !== 4'b1111 || bus.stage_clr !== 4'b0000 || bus.pc_en !== 1'b1) begin
      failures++;
      $display("FAIL reset_comb got en=%b clr=%b pc=%b exp en=1111 clr=0000 pc=1",
               bus.stage_en, bus.stage_clr, bus.pc_en);
    end
    $display("test_reset done failures=%0d", failures);
  endtask

  task automatic test_no_hazard();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive('0, 0, 0, 0, 1);
      checks++;
      if (bus.stage_en !== 4'b1111 || bus.stage_clr !== 4'b0000 || bus.pc_en !== 1'b1) begin
        failures++;
        $display("FAIL nohaz_comb got en=%b clr=%b pc=%b exp en=1111 clr=0000 pc=1",
                 bus.stage_en, bus.stage_clr, bus.pc_en);
      end
    end
    drive('0, 0, 0, 0, 1);
    checks += 2;
    if (bus.pipe_empty !== 1'b0) begin failures++; $display("FAIL nohaz_empty got=%b exp=0", bus.pipe_empty); end
    if (bus.stall_cycles !== '0) begin failures++; $display("FAIL nohaz_stall got=%0d exp=0", bus.stall_cycles); end
    $display("test_no_hazard done failures=%0d", failures);
  endtask

  task automatic test_mem_stall();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(5'b01000, 0, 0, 0, 1);
      checks++;
      if (bus.stage_en !== 4'b1000 || bus.stage_clr !== 4'b1000 || bus.pc_en !== 1'b0) begin
        failures++;
        $display("FAIL memstall_comb got en=%b clr=%b pc=%b exp en=1000 clr=1000 pc=0",
                 bus.stage_en, bus.stage_clr, bus.pc_en);
      end
    end
    drive('0, 0, 0, 0, 1);
    checks++;
    if (bus.stall_cycles !== 8'd3) begin failures++; $display("FAIL memstall_count got=%0d exp=3", bus.stall_cycles); end
    $display("test_mem_stall done failures=%0d", failures);
  endtask

  task automatic test_load_hazard();
    do_reset();
    drive('0, 1, 0, 0, 1);
    checks++;
    if (bus.stage_en !== 4'b1110 || bus.stage_clr !== 4'b0010 || bus.pc_en !== 1'b0) begin
      failures++;
      $display("FAIL loadhaz_comb got en=%b clr=%b pc=%b exp en=1110 clr=0010 pc=0",
               bus.stage_en, bus.stage_clr, bus.pc_en);
    end
    drive('0, 0, 0, 0, 1);
    checks++;
    if (bus.stage_en !== 4'b1111 || bus.pc_en !== 1'b1 || bus.stall_cycles !== 8'd1) begin
      failures++;
      $display("FAIL loadhaz_after got en=%b pc=%b stall=%0d exp en=1111 pc=1 stall=1",
               bus.stage_en, bus.pc_en, bus.stall_cycles);
    end
    $display("test_load_hazard done failures=%0d", failures);
  endtask

  task automatic test_redirect();
    do_reset();
    drive('0, 0, 1, 0, 1);
    checks++;
    if (bus.redirect_ready !== 1'b1 || bus.stage_clr !== 4'b0111 || bus.pc_en !== 1'b1) begin
      failures++;
      $display("FAIL redir_accept got rr=%b clr=%b pc=%b exp rr=1 clr=0111 pc=1",
               bus.redirect_ready, bus.stage_clr, bus.pc_en);
    end
    for (int i = 0; i < 2; i++) begin
      drive(5'b01000, 0, 1, 0, 1);
      checks++;
      if (bus.redirect_ready !== 1'b0 || bus.stage_clr !== 4'b1000 || bus.flush_count !== 8'd1) begin
        failures++;
        $display("FAIL redir_blocked got rr=%b clr=%b flush=%0d exp rr=0 clr=1000 flush=1",
                 bus.redirect_ready, bus.stage_clr, bus.flush_count);
      end
    end
    drive('0, 0, 1, 0, 1);
    checks++;
    if (bus.redirect_ready !== 1'b1) begin failures++; $display("FAIL redir_retry got=%b exp=1", bus.redirect_ready); end
    drive('0, 0, 0, 0, 1);
    checks++;
    if (bus.flush_count !== 8'd2) begin failures++; $display("FAIL redir_count got=%0d exp=2", bus.flush_count); end
    $display("test_redirect done failures=%0d", failures);
  endtask

  task automatic test_fence();
    int n;
    do_reset();
    for (int i = 0; i < 4; i++) drive('0, 0, 0, 0, 1);
    drive('0, 0, 0, 1, 1);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      drive('0, 0, 0, 0, 1);
      if (i == 0) begin
        checks++;
        if (bus.ctrl_state !== 2'b01 || bus.pc_en !== 1'b0 || bus.stage_clr[0] !== 1'b1) begin
          failures++;
          $display("FAIL fence_drain got state=%b pc=%b clr0=%b exp state=01 pc=0 clr0=1",
                   bus.ctrl_state, bus.pc_en, bus.stage_clr[0]);
        end
      end
      if (bus.pipe_empty === 1'b1) break;
      n++;
    end
    checks++;
    if (n != 4) begin failures++; $display("FAIL fence_drain_len got=%0d exp=4", n); end
    drive('0, 0, 0, 0, 1);
    checks++;
    if (bus.ctrl_state !== 2'b10 || bus.fence_ack !== 1'b1) begin
      failures++;
      $display("FAIL fence_ack got state=%b ack=%b exp state=10 ack=1", bus.ctrl_state, bus.fence_ack);
    end
    drive('0, 0, 0, 0, 1);
    checks++;
    if (bus.ctrl_state !== 2'b00 || bus.fence_ack !== 1'b0) begin
      failures++;
      $display("FAIL fence_back got state=%b ack=%b exp state=00 ack=0", bus.ctrl_state, bus.fence_ack);
    end
    $display("test_fence done failures=%0d", failures);
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    for (int i = 0; i < 3; i++) drive('0, 0, 1, 0, 1);
    drive('0, 0, 0, 1, 1);
    drive('0, 0, 0, 0, 1);
    checks++;
    if (bus.ctrl_state !== 2'b01) begin failures++; $display("FAIL middrain_state got=%b exp=01", bus.ctrl_state); end
    drive('0, 0, 0, 0, 0);
    drive('0, 0, 0, 0, 1);
    checks++;
    if (bus.ctrl_state !== 2'b00 || bus.flush_count !== '0 || bus.stall_cycles !== '0 ||
        bus.pipe_empty !== 1'b1 || bus.fence_ack !== 1'b0) begin
      failures++;
      $display("FAIL middrain_reset got state=%b flush=%0d stall=%0d empty=%b ack=%b exp 00 0 0 1 0",
               bus.ctrl_state, bus.flush_count, bus.stall_cycles, bus.pipe_empty, bus.fence_ack);
    end
    $display("test_reset_mid_drain done failures=%0d", failures);
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < CMAX + 5; i++) drive(5'b00001, 0, 0, 0, 1);
    checks++;
    if (bus.stall_cycles !== 8'hFF) begin failures++; $display("FAIL sat_stall got=%0d exp=255", bus.stall_cycles); end
    drive(5'b00001, 0, 0, 0, 1);
    checks++;
    if (bus.stall_cycles !== 8'hFF) begin failures++; $display("FAIL sat_stall_hold got=%0d exp=255", bus.stall_cycles); end
    for (int i = 0; i < CMAX + 3; i++) drive('0, 0, 1, 0, 1);
    checks++;
    if (bus.flush_count !== 8'hFF) begin failures++; $display("FAIL sat_flush got=%0d exp=255", bus.flush_count); end
    $display("test_saturation done failures=%0d", failures);
  endtask

  task automatic test_random();
    logic [NS-1:0] st;
    logic lh, rd, fr, rn;
    logic exp_empty;
    rd = 0;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      for (int j = 0; j < NS; j++) st[j] = ($urandom_range(0, 7) == 0);
      lh = ($urandom_range(0, 9) == 0);
      // A pending redirect is held until it is accepted.
      if (!(rd && !e_rr)) rd = ($urandom_range(0, 7) == 0);
      fr = ($urandom_range(0, 11) == 0);
      rn = ($urandom_range(0, 199) != 0);
      drive(st, lh, rd, fr, rn);
      exp_empty = model_empty();
      checks += 9;
      if (bus.stage_en !== e_en) begin failures++; $display("FAIL rnd_en cyc=%0d got=%b exp=%b", i, bus.stage_en, e_en); end
      if (bus.stage_clr !== e_clr) begin failures++; $display("FAIL rnd_clr cyc=%0d got=%b exp=%b", i, bus.stage_clr, e_clr); end
      if (bus.pc_en !== e_pc) begin failures++; $display("FAIL rnd_pc cyc=%0d got=%b exp=%b", i, bus.pc_en, e_pc); end
      if (bus.redirect_ready !== e_rr) begin failures++; $display("FAIL rnd_rr cyc=%0d got=%b exp=%b", i, bus.redirect_ready, e_rr); end
      if (bus.pipe_empty !== exp_empty) begin failures++; $display("FAIL rnd_empty cyc=%0d got=%b exp=%b", i, bus.pipe_empty, exp_empty); end
      if (bus.ctrl_state !== 2'(m_state)) begin failures++; $display("FAIL rnd_state cyc=%0d got=%b exp=%0d", i, bus.ctrl_state, m_state); end
      if (bus.fence_ack !== (m_state == 2)) begin failures++; $display("FAIL rnd_ack cyc=%0d got=%b exp=%0d", i, bus.fence_ack, m_state == 2); end
      if (bus.stall_cycles !== CW'(m_stall)) begin failures++; $display("FAIL rnd_stall cyc=%0d got=%0d exp=%0d", i, bus.stall_cycles, m_stall); end
      if (bus.flush_count !== CW'(m_flush)) begin failures++; $display("FAIL rnd_flush cyc=%0d got=%0d exp=%0d", i, bus.flush_count, m_flush); end
    end
    $display("test_random done failures=%0d", failures);
  endtask

  initial begin
    checks          = 0;
    failures        = 0;
    rst_n           = 1'b0;
    bus.stall_req   = '0;
    bus.load_hazard = 1'b0;
    bus.redirect    = 1'b0;
    bus.fence_req   = 1'b0;
    m_state         = 0;
    m_stall         = 0;
    m_flush         = 0;
    for (int k = 0; k < NR; k++) m_vld[k] = 0;
    test_reset();
    test_no_hazard();
    test_mem_stall();
    test_load_hazard();
    test_redirect();
    test_fence();
    test_reset_mid_drain();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
